// File: rtl/sdp_fifo_pkg.sv
// Shared sizing defaults and helpers for the SDP FIFO and its distributed RAM.
package sdp_fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    // Registered status flags, all derived from the next-state pointers
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } fifo_flags_t;

    // Ceiling log2; returns 0 for n <= 1
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_fifo_dram.sv
// Simple-dual-port distributed RAM: synchronous write, combinational read with
// an optional two-stage registered read path.
module sdp_fifo_dram
    import sdp_fifo_pkg::*;
#(
    parameter int unsigned RAM_WIDTH       = FIFO_WIDTH,
    parameter int unsigned RAM_DEPTH       = FIFO_DEPTH,
    parameter string       RAM_PERFORMANCE = "LOW_LATENCY",
    localparam int unsigned AW             = clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [RAM_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    input  logic                 en_r_i,
    input  logic                 reg_ce_r_i,
    input  logic                 rst_r_i,
    output logic [RAM_WIDTH-1:0] rdata_o
);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] rd_c;

    // Storage is never reset; only the pointers around it define validity
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_c = mem_q[raddr_i];

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = &{1'b0, en_r_i, reg_ce_r_i, rst_r_i};
        assign rdata_o        = rd_c;
    end else begin : g_high_perf
        logic [RAM_WIDTH-1:0] ram_q;
        logic [RAM_WIDTH-1:0] dout_q;

        // Latch stage then output register with its own sync clear/enable
        always_ff @(posedge clk) begin
            if (en_r_i) begin
                ram_q <= rd_c;
            end
            if (rst_r_i) begin
                dout_q <= '0;
            end else if (reg_ce_r_i) begin
                dout_q <= ram_q;
            end
        end

        assign rdata_o = dout_q;
    end

endmodule

// File: rtl/sdp_fifo.sv
// First-word-fall-through FIFO with valid/ready on both ends; pointers and
// status live here, storage is the SDP distributed RAM.
module sdp_fifo
    import sdp_fifo_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = FIFO_WIDTH,
    parameter int unsigned  DEPTH      = FIFO_DEPTH,
    parameter int unsigned  AF_LEVEL   = DEPTH - 2,
    localparam int unsigned AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;
    fifo_flags_t   flags_q;
    fifo_flags_t   flags_d;

    logic push_c;
    logic pop_c;
    logic ram_we_c;

    // Handshakes qualify only on registered status, so no valid->ready path
    assign push_c   = in_valid && !flags_q.full;
    assign pop_c    = out_ready && !flags_q.empty;
    assign ram_we_c = push_c && !flush;

    // Pointer next state; flush wins over any concurrent push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Status computed from next pointers so the registered copy tracks them exactly
    always_comb begin
        count_d             = wr_ptr_d - rd_ptr_d;
        flags_d.empty       = (wr_ptr_d == rd_ptr_d);
        flags_d.full        = (wr_ptr_d[AW] != rd_ptr_d[AW])
                           && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        flags_d.almost_full = (32'(count_d) >= AF_LEVEL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            count_q             <= '0;
            flags_q.full        <= 1'b0;
            flags_q.empty       <= 1'b1;
            flags_q.almost_full <= (AF_LEVEL == 0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    sdp_fifo_dram #(
        .RAM_WIDTH       (DATA_WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("LOW_LATENCY")
    ) u_ram (
        .clk        (clk),
        .we_i       (ram_we_c),
        .waddr_i    (wr_ptr_q[AW-1:0]),
        .wdata_i    (in_data),
        .raddr_i    (rd_ptr_q[AW-1:0]),
        .en_r_i     (1'b1),
        .reg_ce_r_i (1'b1),
        .rst_r_i    (1'b0),
        .rdata_o    (out_data)
    );

    assign in_ready    = !flags_q.full;
    assign out_valid   = !flags_q.empty;
    assign count       = count_q;
    assign full        = flags_q.full;
    assign empty       = flags_q.empty;
    assign almost_full = flags_q.almost_full;

endmodule

// File: tb/tb_sdp_fifo.sv
// Directed and randomized checks of sdp_fifo against a queue-based reference.
module tb_sdp_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_q[$];

    sdp_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with what the reference queue implies
    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"},     32'(count),       32'(n));
        chk({tag, ".empty"},     32'(empty),       32'(n == 0));
        chk({tag, ".full"},      32'(full),        32'(n == int'(DEPTH)));
        chk({tag, ".afull"},     32'(almost_full), 32'(n >= int'(AF)));
        chk({tag, ".in_ready"},  32'(in_ready),    32'(n != int'(DEPTH)));
        chk({tag, ".out_valid"}, 32'(out_valid),   32'(n != 0));
        if (n != 0) begin
            chk({tag, ".out_data"}, out_data, model_q[0]);
        end
    endtask

    // One clock: drive, take the edge, update the reference, then check
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic f, input string tag);
        int  n;
        bit  do_pop;
        bit  do_push;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        n = model_q.size();
        if (f) begin
            model_q.delete();
        end else begin
            do_pop  = r && (n > 0);
            do_push = v && (n < int'(DEPTH));
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        // Reset asserted from time zero, released between edges
        #12;
        check_state("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_state("idle");

        // Fill with out_ready low, then an ignored 17th push
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, "fill");
            if (i == 12) chk("af_below_level", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at_level", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, "overflow");
        chk("overflow_count", 32'(count), 32'd16);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            chk("drain_head", out_data, 32'h1000 + 32'(i));
            step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Twenty more through the wrapped pointers
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, (i >= 8), 1'b0, "wrap_push");
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, "wrap_drain");
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Steady state at count 5 with simultaneous push and pop
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, "to5");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, "pushpop");
            chk("pushpop_count", 32'(count), 32'd5);
        end

        // At full, push+pop only pops
        for (int i = 0; i < 11; i++) step(1'b1, $urandom, 1'b0, 1'b0, "to16");
        chk("to16_full", 32'(full), 32'd1);
        step(1'b1, 32'h0000_BEEF, 1'b1, 1'b0, "full_pushpop");
        chk("full_pushpop_count", 32'(count), 32'd15);

        // Flush with a concurrent push at count 7
        step(1'b0, 32'h0, 1'b0, 1'b1, "flush0");
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0, "to7");
        chk("to7_count", 32'(count), 32'd7);
        step(1'b1, 32'h0000_F1F1, 1'b0, 1'b1, "flush_push");
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        step(1'b1, 32'h0000_2222, 1'b0, 1'b0, "post_flush");
        chk("post_flush_head", out_data, 32'h0000_2222);

        // Randomized traffic: a filling phase then a draining phase
        for (int i = 0; i < 400; i++) begin
            step((i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom,
                 (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 60) == 0), "random");
        end

        // Asynchronous reset between edges at count 9
        step(1'b0, 32'h0, 1'b0, 1'b1, "flush1");
        for (int i = 0; i < 9; i++) step(1'b1, $urandom, 1'b0, 1'b0, "to9");
        chk("to9_count", 32'(count), 32'd9);
        in_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        model_q.delete();
        check_state("async_rst");
        #2;
        rstn = 1'b1;
        step(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, "after_rst");
        chk("after_rst_valid", 32'(out_valid), 32'd1);
        chk("after_rst_head", out_data, 32'h0000_ABCD);
        step(1'b0, 32'h0, 1'b1, 1'b0, "final_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_fifo.md
# sdp_fifo

Synchronous first-word-fall-through FIFO that drives the write and read ports of the codebase's simple-dual-port distributed RAM. It generates write address, write data and write enable on the push side, and the read address on the pop side. Valid/ready handshakes sit on both ends. It is the standard decoupling buffer between pipeline stages, for example a store queue or an instruction-fetch buffer, in the LoongArch core.

## Interface
- DATA_WIDTH, default 32: payload width in bits.
- DEPTH, default 16: number of entries; must be a power of two, at least 2.
- AF_LEVEL, default DEPTH-2: `almost_full` asserts when count >= AF_LEVEL.
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  producer presents `in_data`.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  DATA_WIDTH  head entry, combinational from RAM.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.

## Operation
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)+1 bits wide. The low bits address the RAM. The MSB is the wrap bit.
- full = (wr_ptr MSB != rd_ptr MSB) && (low bits equal). empty = (wr_ptr == rd_ptr).
- count = wr_ptr - rd_ptr, taken modulo 2^(clog2(DEPTH)+1).
- push = in_valid && in_ready. On push, the RAM write enable equals push, the write address is the low bits of wr_ptr, and wr_ptr increments.
- pop = out_valid && out_ready. On pop, rd_ptr increments.
- RAM read address is always the low bits of rd_ptr. `out_data` is the RAM's combinational read (low-latency mode), so the head is visible without a read cycle.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full: in_ready = 0, so no push occurs even if a pop happens in the same cycle. There is no full-side pass-through.
- Empty: out_valid = 0. There is no write-to-read bypass, so a pushed word appears at the head on the next cycle.
- Pointer wrap: low bits roll over from DEPTH-1 to 0, and the MSB toggles.
- flush: both pointers go to 0 on the next edge. flush dominates a simultaneous push or pop; the flush-cycle push is dropped and the RAM write is suppressed.
- Reset (async assert): wr_ptr = rd_ptr = 0, giving count = 0, empty = 1, full = 0, out_valid = 0, in_ready = 1, almost_full = 0.
- Reset mid-operation discards all entries. RAM contents are not cleared.
- out_data is undefined while empty and must not be checked by the bench.

## Timing
- Push-to-visible latency is 1 cycle: a word pushed at edge N is at out_data with out_valid = 1 after edge N.
- Pop latency is 0: out_data reflects the next entry immediately after the popping edge.
- All status outputs (full, empty, count, almost_full, in_ready, out_valid) are pure functions of the registered pointers, so they are glitch-free relative to clk.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.
- Combinational path from rd_ptr to out_data: the RAM read path is the only read-side logic.
- The handshake source must hold valid and data until ready. The FIFO never retracts out_valid without a pop, flush or reset.

## Structure
- Add FIFO_WIDTH and FIFO_DEPTH `define` defaults to CPU_Parameter.vh. Parameters DATA_WIDTH and DEPTH default to these.
- Add a clog2 helper there, shared with the RAM.
- One sub-module: instantiate DRAM_SDP with RAM_WIDTH = DATA_WIDTH, RAM_DEPTH = DEPTH, RAM_PERFORMANCE = "LOW_LATENCY", and en_r/reg_ce_r tied to 1, rst_r tied to 0.
- The pointer and status logic stays local to sdp_fifo.

## Test plan
- Reset then idle: rstn low, then high → count = 0, empty = 1, in_ready = 1, out_valid = 0.
- Fill: push 0x1000..0x100F with DEPTH = 16 and out_ready = 0.
  - After 14 pushes almost_full = 1.
  - After 16 pushes full = 1 and in_ready = 0.
  - A 17th in_valid is ignored.
- Drain in order with wrap: after the fill, pop 16 words → out_data sequence 0x1000..0x100F, then empty = 1. Then push 20 more and pop all, so the pointers wrap → order is preserved.
- Simultaneous push/pop at count = 5 for 10 cycles → count stays 5 and the data order is preserved. At full with out_ready = 1 and in_valid = 1 → one pop, no push, count = 15.
- Flush together with push at count = 7 → next cycle count = 0, empty = 1, and the flushed word never appears.
- Async reset asserted mid-stream at count = 9, between clock edges → outputs take reset values immediately. After release, a push of 0xABCD appears at the head one cycle later.
